// File: rtl/spi_frame_decoder.sv
// rtl/spi_frame_decoder.sv - SPI receive-path decoder: serial bits to header and payload words
// Header, payload words and end of frame each produce a one-cycle registered strobe.
module spi_frame_decoder #(
    parameter int HDR_WL       = 6,
    parameter int PAY_WL       = 16,
    parameter int NWORDS       = 4,
    parameter int LEN_FROM_HDR = 0,
    parameter int LEN_WL       = 3,
    parameter int IDX_WL       = 8,
    parameter int MSB_FIRST    = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCLR,
    input  logic              iEN,
    input  logic              iMOSI,
    output logic [HDR_WL-1:0] oHEADER,
    output logic              oHEADER_EN,
    output logic [PAY_WL-1:0] oDATA,
    output logic              oDATA_EN,
    output logic [IDX_WL-1:0] oWORD_IDX,
    output logic              oFRAME_DONE,
    output logic              oBUSY
);

    localparam int SR_WL  = (HDR_WL > PAY_WL) ? HDR_WL : PAY_WL;
    localparam int CNT_WL = $clog2(SR_WL + 1);

    localparam logic [CNT_WL-1:0] HDR_LAST  = CNT_WL'(HDR_WL - 1);
    localparam logic [CNT_WL-1:0] PAY_LAST  = CNT_WL'(PAY_WL - 1);
    localparam logic [IDX_WL-1:0] NWORDS_C  = IDX_WL'(NWORDS);
    localparam logic [IDX_WL-1:0] IDX_ONE   = IDX_WL'(1);

    typedef enum logic {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SR_WL-1:0]    sr_q, sr_d;
    logic [CNT_WL-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_WL-1:0]   word_cnt_q, word_cnt_d;
    logic [IDX_WL-1:0]   nwords_q, nwords_d;
    logic [HDR_WL-1:0]   header_q, header_d;
    logic                header_en_q, header_en_d;
    logic [PAY_WL-1:0]   data_q, data_d;
    logic                data_en_q, data_en_d;
    logic [IDX_WL-1:0]   word_idx_q, word_idx_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;

    logic [SR_WL-1:0]    sr_next;
    logic [HDR_WL-1:0]   hdr_val;
    logic [PAY_WL-1:0]   pay_val;
    logic [IDX_WL-1:0]   len_val;

    // The completed field sits where the shift direction leaves it: low bits
    // when shifting left, high bits when shifting right.
    assign sr_next = (MSB_FIRST != 0) ? {sr_q[SR_WL-2:0], iMOSI}
                                      : {iMOSI, sr_q[SR_WL-1:1]};
    assign hdr_val = (MSB_FIRST != 0) ? sr_next[HDR_WL-1:0]
                                      : sr_next[SR_WL-1 -: HDR_WL];
    assign pay_val = (MSB_FIRST != 0) ? sr_next[PAY_WL-1:0]
                                      : sr_next[SR_WL-1 -: PAY_WL];
    assign len_val = (LEN_FROM_HDR != 0) ? IDX_WL'(hdr_val[LEN_WL-1:0]) : NWORDS_C;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        nwords_d     = nwords_q;
        header_d     = header_q;
        data_d       = data_q;
        word_idx_d   = word_idx_q;
        header_en_d  = 1'b0;
        data_en_d    = 1'b0;
        frame_done_d = 1'b0;

        if (iCLR) begin
            state_d    = ST_HDR;
            sr_d       = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            header_d   = '0;
            data_d     = '0;
            word_idx_d = '0;
        end else if (iEN) begin
            sr_d = sr_next;
            unique case (state_q)
                ST_HDR: begin
                    if (bit_cnt_q == HDR_LAST) begin
                        header_d    = hdr_val;
                        header_en_d = 1'b1;
                        bit_cnt_d   = '0;
                        word_cnt_d  = '0;
                        nwords_d    = len_val;
                        if (len_val == '0) begin
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_PAY;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_PAY: begin
                    if (bit_cnt_q == PAY_LAST) begin
                        data_d     = pay_val;
                        data_en_d  = 1'b1;
                        word_idx_d = word_cnt_q;
                        word_cnt_d = word_cnt_q + IDX_ONE;
                        bit_cnt_d  = '0;
                        if (word_cnt_q == nwords_q - IDX_ONE) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_HDR;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end

        busy_d = (state_d == ST_PAY) || (bit_cnt_d != '0);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= ST_HDR;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            nwords_q     <= '0;
            header_q     <= '0;
            header_en_q  <= 1'b0;
            data_q       <= '0;
            data_en_q    <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            nwords_q     <= nwords_d;
            header_q     <= header_d;
            header_en_q  <= header_en_d;
            data_q       <= data_d;
            data_en_q    <= data_en_d;
            word_idx_q   <= word_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign oHEADER     = header_q;
    assign oHEADER_EN  = header_en_q;
    assign oDATA       = data_q;
    assign oDATA_EN    = data_en_q;
    assign oWORD_IDX   = word_idx_q;
    assign oFRAME_DONE = frame_done_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb/tb_spi_frame_decoder.sv - scoreboard bench for spi_frame_decoder
// Instance 0: defaults, 1: LSB-first, 2: word count from header.
module tb_spi_frame_decoder;

    localparam int HW = 6;
    localparam int PW = 16;
    localparam int NW = 4;
    localparam int LW = 3;
    localparam int IW = 8;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic clr  = 1'b0;
    logic mosi = 1'b0;
    int   sel  = 0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [HW-1:0] hdr_o  [3];
    logic          hen_o  [3];
    logic [PW-1:0] dat_o  [3];
    logic          den_o  [3];
    logic [IW-1:0] idx_o  [3];
    logic          done_o [3];
    logic          busy_o [3];

    spi_frame_decoder #(.HDR_WL(HW), .PAY_WL(PW), .NWORDS(NW), .LEN_FROM_HDR(0),
                        .LEN_WL(LW), .IDX_WL(IW), .MSB_FIRST(1)) u_dut_a (
        .iCLK(clk), .iRST(rst), .iCLR(clr && (sel == 0)), .iEN(en && (sel == 0)),
        .iMOSI(mosi), .oHEADER(hdr_o[0]), .oHEADER_EN(hen_o[0]), .oDATA(dat_o[0]),
        .oDATA_EN(den_o[0]), .oWORD_IDX(idx_o[0]), .oFRAME_DONE(done_o[0]), .oBUSY(busy_o[0]));

    spi_frame_decoder #(.HDR_WL(HW), .PAY_WL(PW), .NWORDS(NW), .LEN_FROM_HDR(0),
                        .LEN_WL(LW), .IDX_WL(IW), .MSB_FIRST(0)) u_dut_b (
        .iCLK(clk), .iRST(rst), .iCLR(clr && (sel == 1)), .iEN(en && (sel == 1)),
        .iMOSI(mosi), .oHEADER(hdr_o[1]), .oHEADER_EN(hen_o[1]), .oDATA(dat_o[1]),
        .oDATA_EN(den_o[1]), .oWORD_IDX(idx_o[1]), .oFRAME_DONE(done_o[1]), .oBUSY(busy_o[1]));

    spi_frame_decoder #(.HDR_WL(HW), .PAY_WL(PW), .NWORDS(NW), .LEN_FROM_HDR(1),
                        .LEN_WL(LW), .IDX_WL(IW), .MSB_FIRST(1)) u_dut_c (
        .iCLK(clk), .iRST(rst), .iCLR(clr && (sel == 2)), .iEN(en && (sel == 2)),
        .iMOSI(mosi), .oHEADER(hdr_o[2]), .oHEADER_EN(hen_o[2]), .oDATA(dat_o[2]),
        .oDATA_EN(den_o[2]), .oWORD_IDX(idx_o[2]), .oFRAME_DONE(done_o[2]), .oBUSY(busy_o[2]));

    typedef struct {
        int          kind;   // 0 header, 1 payload word
        logic [15:0] val;
        logic [7:0]  idx;
        logic        done;
        int          due;
    } ev_t;

    ev_t         exp_q [3][$];
    logic [15:0] last_hdr  [3];
    logic [15:0] last_data [3];
    logic [7:0]  last_idx  [3];
    int          done_cyc [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    initial begin
        if (NW >= (1 << IW) || ((1 << LW) - 1) >= (1 << IW)) begin
            $display("FAIL param_range: NWORDS=%0d LEN_WL=%0d IDX_WL=%0d", NW, LW, IW);
            $fatal(1, "word counter too narrow");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic [15:0] h, input logic he,
                       input logic [15:0] dt, input logic de, input logic [7:0] ix,
                       input logic dn);
        ev_t e;
        check($sformatf("d%0d_strobe_excl", d), 32'(he & de), 0);
        if (he || de) begin
            if (exp_q[d].size() == 0) begin
                check($sformatf("d%0d_spurious_strobe", d), 1, 0);
            end else begin
                e = exp_q[d].pop_front();
                check($sformatf("d%0d_kind", d), he ? 0 : 1, 32'(e.kind));
                check($sformatf("d%0d_latency", d), 32'(cyc), 32'(e.due));
                check($sformatf("d%0d_frame_done", d), 32'(dn), 32'(e.done));
                if (e.kind == 0) begin
                    check($sformatf("d%0d_header", d), 32'(h), 32'(e.val));
                    last_hdr[d] = e.val;
                end else begin
                    check($sformatf("d%0d_data", d), 32'(dt), 32'(e.val));
                    check($sformatf("d%0d_word_idx", d), 32'(ix), 32'(e.idx));
                    last_data[d] = e.val;
                    last_idx[d]  = e.idx;
                end
            end
        end else begin
            check($sformatf("d%0d_done_alone", d), 32'(dn), 0);
        end
        if (!he) check($sformatf("d%0d_hdr_hold", d), 32'(h), 32'(last_hdr[d]));
        if (!de) begin
            check($sformatf("d%0d_data_hold", d), 32'(dt), 32'(last_data[d]));
            check($sformatf("d%0d_idx_hold", d), 32'(ix), 32'(last_idx[d]));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++)
                mon(d, 16'(hdr_o[d]), hen_o[d], dat_o[d], den_o[d], idx_o[d], done_o[d]);
            if (done_o[0]) done_cyc.push_back(cyc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) repeat ($urandom_range(0, 4)) tick;
        en   = 1'b1;
        mosi = b;
        tick;
        en   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] v, input int w, input bit msb, input bit gap);
        for (int i = 0; i < w; i++) send_bit(msb ? v[w-1-i] : v[i], gap);
    endtask

    // Strobe is registered on the edge that samples the last bit.
    task automatic push(input int d, input int kind, input logic [15:0] v,
                        input logic [7:0] ix, input logic dn);
        ev_t e;
        e.kind = kind;
        e.val  = v;
        e.idx  = ix;
        e.done = dn;
        e.due  = cyc;
        exp_q[d].push_back(e);
    endtask

    task automatic send_frame(input int d, input logic [15:0] hdr, input int n,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3,
                              input bit msb, input bit gap);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        send_word(hdr, HW, msb, gap);
        push(d, 0, hdr, 8'd0, n == 0);
        for (int i = 0; i < n; i++) begin
            send_word(w[i], PW, msb, gap);
            push(d, 1, w[i], 8'(i), i == n - 1);
        end
    endtask

    task automatic zero_last(input int d);
        last_hdr[d]  = '0;
        last_data[d] = '0;
        last_idx[d]  = '0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) zero_last(d);
        repeat (3) tick;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_rst_hdr", d), 32'(hdr_o[d]), 0);
            check($sformatf("d%0d_rst_data", d), 32'(dat_o[d]), 0);
            check($sformatf("d%0d_rst_idx", d), 32'(idx_o[d]), 0);
            check($sformatf("d%0d_rst_busy", d), 32'(busy_o[d]), 0);
            check($sformatf("d%0d_rst_strobes", d), 32'({hen_o[d], den_o[d], done_o[d]}), 0);
        end
        rst = 1'b0;
        tick;

        // Defaults, continuous iEN
        sel = 0;
        send_frame(0, 16'h002D, 4, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 1, 0);
        check("a_busy_after_frame", 32'(busy_o[0]), 0);
        repeat (3) tick;

        // LSB-first
        sel = 1;
        send_frame(1, 16'h0001, 4, 16'h0001, 16'h8000, 16'h1234, 16'hABCD, 0, 0);
        check("b_busy_after_frame", 32'(busy_o[1]), 0);
        repeat (3) tick;

        // Length from header, including a zero-length header followed immediately by a new one
        sel = 2;
        send_frame(2, 16'h0002, 2, 16'h00FF, 16'h5A5A, 16'h0, 16'h0, 1, 0);
        send_frame(2, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0);
        check("c_busy_after_empty", 32'(busy_o[2]), 0);
        send_frame(2, 16'h0001, 1, 16'h0F0F, 16'h0, 16'h0, 16'h0, 1, 0);
        check("c_busy_after_frame", 32'(busy_o[2]), 0);
        repeat (3) tick;

        // Gapped iEN
        sel = 0;
        send_frame(0, 16'h002D, 4, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 1, 1);
        repeat (3) tick;

        // Abort mid-word
        send_frame(0, 16'h002D, 1, 16'h1234, 16'h0, 16'h0, 16'h0, 1, 0);
        exp_q[0][$].done = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(16'hABCD >> (15 - i), 0);
        check("a_busy_mid_word", 32'(busy_o[0]), 1);
        en = 1'b1; clr = 1'b1; mosi = 1'b1;
        tick;
        en = 1'b0; clr = 1'b0;
        zero_last(0);
        check("a_clr_busy", 32'(busy_o[0]), 0);
        check("a_clr_hdr", 32'(hdr_o[0]), 0);
        check("a_clr_data", 32'(dat_o[0]), 0);
        check("a_clr_idx", 32'(idx_o[0]), 0);
        tick;
        send_frame(0, 16'h0033, 4, 16'hCAFE, 16'h0001, 16'h8000, 16'h7FFF, 1, 0);
        check("a_busy_after_fresh", 32'(busy_o[0]), 0);
        repeat (2) tick;

        // Async reset between clock edges, mid-header
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        check("a_busy_mid_hdr", 32'(busy_o[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("a_arst_hdr", 32'(hdr_o[0]), 0);
        check("a_arst_data", 32'(dat_o[0]), 0);
        check("a_arst_idx", 32'(idx_o[0]), 0);
        check("a_arst_busy", 32'(busy_o[0]), 0);
        for (int d = 0; d < 3; d++) zero_last(d);
        repeat (2) tick;
        rst = 1'b0;
        tick;
        done_cyc.delete();
        send_frame(0, 16'h002D, 4, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 1, 0);
        send_frame(0, 16'h0015, 4, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 1, 0);
        check("a_b2b_busy_end", 32'(busy_o[0]), 0);
        repeat (3) tick;
        check("a_b2b_done_count", 32'(done_cyc.size()), 2);
        if (done_cyc.size() == 2)
            check("a_b2b_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 70);

        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_leftover", d), 32'(exp_q[d].size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
Serial-to-parallel frame decoder on the SPI receive path. It samples one MOSI bit per iEN strobe and assembles an HDR_WL-bit header. It then assembles a header-selected or fixed number of PAY_WL-bit payload words. Header, payload words and end of frame are each reported with single-cycle registered strobes to the downstream command/sample logic.

Parameters:
HDR_WL, 6, header width in bits (>=2)
PAY_WL, 16, payload word width in bits (>=2)
NWORDS, 4, payload words per frame when LEN_FROM_HDR=0 (0 = header-only frames)
LEN_FROM_HDR, 0, 1 = word count taken from oHEADER[LEN_WL-1:0]
LEN_WL, 3, header length-field width (<=HDR_WL, <=IDX_WL)
IDX_WL, 8, word index / word counter width
MSB_FIRST, 1, 1 = first received bit lands in MSB; 0 = first bit lands in LSB

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-high reset
iCLR  in  1  synchronous frame abort (e.g. CS deassert)
iEN  in  1  bit-valid strobe; MOSI sampled on iCLK rising edge when high
iMOSI  in  1  serial data bit
oHEADER  out  HDR_WL  last complete header, held until next header/clear
oHEADER_EN  out  1  one-cycle pulse: oHEADER updated this cycle
oDATA  out  PAY_WL  last complete payload word, held
oDATA_EN  out  1  one-cycle pulse: oDATA updated this cycle
oWORD_IDX  out  IDX_WL  index of word on oDATA (0-based)
oFRAME_DONE  out  1  one-cycle pulse: frame complete
oBUSY  out  1  high while a frame is partially received

Behaviour:
- Reset is asynchronous and active-high: iRST high sets all outputs, shift register, bit counter and word counter to 0, and state to HDR.
- States: HDR (collect header bits), PAY (collect payload words).
- Shift: MSB_FIRST=1 shifts left with the new bit entering at bit 0. MSB_FIRST=0 shifts right with the new bit entering at the MSB. The register is only as wide as needed (max(HDR_WL, PAY_WL)); unused upper bits are ignored for header.
- iEN low: all state holds; strobes low.
- HDR: each iEN increments bit counter. On the HDR_WL-th bit, the next cycle has:
  - oHEADER = assembled header and oHEADER_EN = 1 (latency 1 cycle from last bit's iEN).
  - Bit counter is reset to 0.
  - Word count is latched: NWORDS, or header[LEN_WL-1:0] if LEN_FROM_HDR.
  - If word count = 0: oFRAME_DONE = 1 in the same cycle as oHEADER_EN, and the state stays HDR. Otherwise the state moves to PAY with the word counter at 0.
- PAY: on the PAY_WL-th bit of a word, the next cycle has:
  - oDATA = word, oDATA_EN = 1, oWORD_IDX = word counter, and the word counter increments.
  - If this was word count-1, oFRAME_DONE = 1 in the same cycle and the state returns to HDR.
- Back-to-back: iEN may be high every cycle. A bit sampled in the cycle a strobe is output belongs to the next word/frame; no bit is lost.
- oBUSY = (state==PAY) or (bit counter != 0), registered alongside state. It is low in the cycle oFRAME_DONE pulses unless a new bit was already sampled.
- iCLR has priority over iEN in the same cycle:
  - Sampled bit discarded.
  - State returns to HDR.
  - Bit counter, word counter and shift register are cleared to 0.
  - oHEADER, oDATA and oWORD_IDX are cleared to 0.
  - All strobes are low next cycle.
  - iCLR mid-word or mid-header produces no partial strobe.
- Counters never wrap within a frame. The word counter is sized by IDX_WL; NWORDS and 2^LEN_WL-1 must both be < 2^IDX_WL. The bench asserts this at elaboration.
- Strobes are mutually consistent: oDATA_EN and oHEADER_EN are never high in the same cycle. oFRAME_DONE is only high together with one of them.

Test Plan:
- Defaults, iEN every cycle, header 6'b101101 then 4 words 0x1234, 0xABCD, 0x0000, 0xFFFF MSB-first:
  - oHEADER=0x2D with oHEADER_EN one cycle after 6th bit.
  - Four oDATA_EN pulses with oWORD_IDX 0..3.
  - oFRAME_DONE with word 3 only.
- MSB_FIRST=0, header bits sent 1,0,0,0,0,0 -> oHEADER=6'b000001; payload first bit 1 then 15 zeros -> oDATA=0x0001.
- LEN_FROM_HDR=1:
  - Header 6'b000010 -> exactly 2 words, then oFRAME_DONE.
  - Header 6'b000000 -> oHEADER_EN and oFRAME_DONE in the same cycle, no oDATA_EN, and the next bit starts a new header.
- iEN gapped randomly (1 of 3 cycles) with same frame as test 1 -> identical output values/order. Strobes are one cycle wide, and outputs hold between strobes.
- iCLR asserted after 9 payload bits of word 1 (same cycle as an iEN):
  - No oDATA_EN; oBUSY=0 and outputs 0 next cycle.
  - A fresh 6+64-bit frame afterwards decodes correctly from header.
- iRST asserted asynchronously mid-header (between clock edges) -> all outputs 0 immediately. After release, a full frame decodes correctly; two frames back-to-back with no idle cycle give two oFRAME_DONE pulses 64+6 bit-cycles apart.
